pla_sop_pipe: RTL and testbench
===============================

Name: pla_sop_pipe

Overview:
- Parametrised, programmable sum-of-products evaluator. It generalises the fixed 5-variable implicant OR blocks used for the logic-minimisation exercises.
- Holds a runtime-loadable table of N_TERMS implicants over N_IN variables.
- Evaluates each accepted input vector through a 2-stage valid/ready pipeline. Returns the function value plus the per-implicant hit vector.
- Sits between the stimulus source (switches or test sequencer) and the result display/checker.

Parameters:
- N_IN, 5, number of boolean input variables. Range 1..16.
- N_TERMS, 8, number of implicant slots. Range 1..32.
- IDX_W, $clog2(N_TERMS) (minimum 1), width of the config index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  implicant slot to write.
- cfg_en  in  1  slot enable value to write.
- cfg_mask  in  N_IN  literal-present mask; bit=1 means the variable appears in the term.
- cfg_val  in  N_IN  literal polarity; 1 = true literal, 0 = complemented.
- in_valid  in  1  input vector offered.
- in_data  in  N_IN  variable vector; bit N_IN-1 is the first variable (X), bit 0 the last.
- in_ready  out  1  pipeline can accept in_data this cycle.
- out_valid  out  1  result held on outputs.
- out_ready  in  1  consumer accepts the result.
- out_f  out  1  OR of all hits.
- out_hits  out  N_TERMS  per-slot match vector.

Behaviour:
- Term match:
  - hit[i] = en[i] & (((in_data ^ val[i]) & mask[i]) == 0).
  - A slot with mask=0 and en=1 is a constant-1 term.
  - out_f = |hits.
- Reset (async assert, sync-safe deassert by system):
  - All en, mask and val slots clear to 0.
  - Both stage-valid flags clear to 0.
  - out_valid=0, out_f=0, out_hits=0, in_ready=1 in the first cycle after reset.
- Reset mid-operation: in-flight vectors are discarded and the table is lost. No result is produced for them.
- Stage 1 (s1) registers the hit vector computed from in_data and the table as it stood before the clock edge.
- Stage 2 (s2) is the output register: out_hits and out_f.
- Handshake rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; it is the only comb path.
  - Accept on in_valid & in_ready.
  - out_valid = s2_valid.
  - out_hits and out_f stay stable while out_valid & !out_ready.
- Latency and throughput: exactly 2 cycles from the accept edge to out_valid when out_ready=1. One result per cycle sustained. Back-pressure stalls both stages without loss or duplication.
- Config writes:
  - Take effect on the clock edge of cfg_we.
  - A vector accepted on that same edge uses the old table.
  - Vectors already in s1 or s2 are unaffected.
  - cfg_idx >= N_TERMS is ignored with no state change.
  - Writes are legal at any time, including during stalls.
- Simultaneous in accept and cfg_we to the same slot: the old entry is used for that vector, the new entry for the next one.

Decomposition:
- Shared package pla_pkg holds:
  - The implicant struct {en, mask[N_IN], val[N_IN]}.
  - The MAX_N_IN/MAX_TERMS limits.
  - A function term_hit(vec, entry).
- One sub-module is natural: pla_term_table. It is the slot register array with write port and reset clear, and outputs the combinational hit vector for a given input. The top level holds the two pipeline stages and the handshake.

Test Plan:
- Reset then in_valid=1, in_data=5'b10101 with the table empty -> after 2 cycles out_valid=1, out_f=0, out_hits=8'h00; in_ready=1 throughout.
- Program slot0 mask=5'b11001 val=5'b00000, slot1 mask=5'b01110 val=5'b00010 (both en=1). Send 5'b00100 -> out_hits=8'h01, out_f=1. Send 5'b10010 -> out_hits=8'h02, out_f=1. Send 5'b11111 -> out_f=0.
- Stream 6 vectors back-to-back with out_ready=0 for cycles 3..6 -> in_ready drops after 2 accepted. All 6 results emerge in order, each held stable while stalled, none duplicated.
- cfg_we disables slot0 on the same edge that accepts 5'b00100 -> that result has hit0=1. The next 5'b00100 gives out_hits=8'h00.
- Slot7 mask=0, en=1 -> every vector has out_f=1 and out_hits[7]=1. Write cfg_idx=8 with N_TERMS=8 -> no change.
- Assert rst while two results are in flight -> out_valid=0 immediately (async), table cleared, no stale result after release.

Source files
------------

// File: rtl/pla_pkg.sv
// pla_pkg -- shared types and helpers for the programmable sum-of-products
// evaluator (pla_sop_pipe).
//
// Contents:
//   MAX_N_IN / MAX_TERMS : upper limits for the N_IN / N_TERMS parameters.
//   implicant_t          : one implicant slot {en, mask, val}, sized to the maximum
//                          variable count. Narrower instances zero-fill the upper
//                          bits, so those bits never take part in a match.
//   term_hit()           : match test of one input vector against one slot.
//   idx_width()          : width of a slot index, never less than 1.
package pla_pkg;

  localparam int MAX_N_IN  = 16;
  localparam int MAX_TERMS = 32;

  typedef struct packed {
    logic                en;
    logic [MAX_N_IN-1:0] mask;  // 1 = variable appears in the term
    logic [MAX_N_IN-1:0] val;   // 1 = true literal, 0 = complemented
  } implicant_t;

  // A term hits when every literal it contains agrees with the input. An
  // enabled term with an empty mask contains no literals, so it is constant 1.
  function automatic logic term_hit(input logic [MAX_N_IN-1:0] vec,
                                    input implicant_t          entry);
    return entry.en & (((vec ^ entry.val) & entry.mask) == '0);
  endfunction

  function automatic int idx_width(input int n_terms);
    return (n_terms > 1) ? $clog2(n_terms) : 1;
  endfunction

endpackage

// File: rtl/pla_sop_pipe_if.sv
// pla_sop_pipe_if -- bundles the configuration port, the input stream and the
// result stream of pla_sop_pipe.
//
// Signals:
//   cfg_we, cfg_idx, cfg_en, cfg_mask, cfg_val : implicant table write port
//   in_valid, in_data, in_ready                : input vector stream
//   out_valid, out_ready, out_f, out_hits      : result stream
//
// Modports:
//   master : stimulus side (drives cfg_*, in_valid, in_data, out_ready)
//   slave  : the evaluator (drives in_ready, out_valid, out_f, out_hits)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// 1. The producer holds valid and its payload steady until that edge, and
// ready may depend combinationally on the opposite side's ready but never on
// valid.
interface pla_sop_pipe_if
  import pla_pkg::*;
#(
  parameter int N_IN    = 5,
  parameter int N_TERMS = 8,
  parameter int IDX_W   = idx_width(N_TERMS)
);

  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic               cfg_en;
  logic [N_IN-1:0]    cfg_mask;
  logic [N_IN-1:0]    cfg_val;

  logic               in_valid;
  logic [N_IN-1:0]    in_data;
  logic               in_ready;

  logic               out_valid;
  logic               out_ready;
  logic               out_f;
  logic [N_TERMS-1:0] out_hits;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_mask, cfg_val,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_f, out_hits
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_mask, cfg_val,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_f, out_hits
  );

endinterface

// File: rtl/pla_term_table.sv
// pla_term_table -- runtime-loadable implicant table with a combinational
// match vector.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears every slot)
//   cfg_we     : write strobe; the slot selected by cfg_idx takes
//                {cfg_en, cfg_mask, cfg_val} on the rising edge
//   cfg_idx    : slot to write; values >= N_TERMS select no slot
//   vec        : input vector to evaluate
//   hits       : per-slot match of vec against the table as currently stored
module pla_term_table
  import pla_pkg::*;
#(
  parameter int N_IN    = 5,
  parameter int N_TERMS = 8,
  parameter int IDX_W   = idx_width(N_TERMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [N_IN-1:0]    cfg_mask,
  input  logic [N_IN-1:0]    cfg_val,
  input  logic [N_IN-1:0]    vec,
  output logic [N_TERMS-1:0] hits
);

  implicant_t          slot_q [N_TERMS];
  implicant_t          wr_entry;
  logic [MAX_N_IN-1:0] vec_ext;

  // Unused upper literal bits stay zero, so they can never block a match.
  always_comb begin
    wr_entry                = '0;
    wr_entry.en             = cfg_en;
    wr_entry.mask[N_IN-1:0] = cfg_mask;
    wr_entry.val[N_IN-1:0]  = cfg_val;
  end

  // Decoding by equality against each slot number means an out-of-range index
  // simply matches nothing and leaves the table untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TERMS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < N_TERMS; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          slot_q[i] <= wr_entry;
        end
      end
    end
  end

  assign vec_ext = MAX_N_IN'(vec);

  always_comb begin
    hits = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      hits[i] = term_hit(vec_ext, slot_q[i]);
    end
  end

endmodule

// File: rtl/pla_sop_pipe.sv
// pla_sop_pipe -- programmable sum-of-products evaluator with a two-stage
// valid/ready pipeline.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset; clears the table and both stages
//   bus  : pla_sop_pipe_if slave modport
//            cfg_*             table write port (effective on the cfg_we edge)
//            in_valid/in_data  vector offered; in_ready = stage 1 can advance
//            out_valid         result held in stage 2
//            out_f/out_hits    OR of hits / per-slot hit vector
//
// Stage 1 registers the hit vector of the accepted vector, computed against the
// table as it stood before the accepting edge. A table write on that same edge
// therefore only affects later vectors. Stage 2 is the output register. Each
// stage advances when it is empty or when the stage after it advances. This
// gives one result per cycle and lossless back-pressure. The only combinational
// input-to-output path is out_ready -> in_ready.
module pla_sop_pipe
  import pla_pkg::*;
#(
  parameter int N_IN    = 5,
  parameter int N_TERMS = 8,
  parameter int IDX_W   = idx_width(N_TERMS)
) (
  input  logic           clk,
  input  logic           rst,
  pla_sop_pipe_if.slave  bus
);

  logic [N_TERMS-1:0] tbl_hits;

  logic               s1_valid;
  logic [N_TERMS-1:0] s1_hits;
  logic               s2_valid;
  logic [N_TERMS-1:0] s2_hits;
  logic               s2_f;

  logic               s1_adv;
  logic               s2_adv;
  logic               accept;

  pla_term_table #(
    .N_IN    (N_IN),
    .N_TERMS (N_TERMS),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (bus.cfg_we),
    .cfg_idx  (bus.cfg_idx),
    .cfg_en   (bus.cfg_en),
    .cfg_mask (bus.cfg_mask),
    .cfg_val  (bus.cfg_val),
    .vec      (bus.in_data),
    .hits     (tbl_hits)
  );

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign accept = bus.in_valid && s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hits  <= '0;
      s2_valid <= 1'b0;
      s2_hits  <= '0;
      s2_f     <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (accept) begin
          s1_hits <= tbl_hits;
        end
      end
      // Payload only moves with a valid beat. A stalled or drained output
      // register keeps its last value.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_hits <= s1_hits;
          s2_f    <= |s1_hits;
        end
      end
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_hits  = s2_hits;
  assign bus.out_f     = s2_f;

endmodule

// File: tb/tb_pla_sop_pipe.sv
// tb_pla_sop_pipe -- self-checking bench for pla_sop_pipe (N_IN=5, N_TERMS=8,
// IDX_W widened to 4 so that slot index 8 can be driven).
//
// The reference model keeps the implicant table as plain arrays and the
// in-flight results as a queue. A result becomes visible on the edge after the
// edge that accepted it, and it leaves on an edge where out_ready is 1.
// Two results in flight with out_ready low means the input side is full.
module tb_pla_sop_pipe;

  localparam int NI = 5;
  localparam int NT = 8;
  localparam int IW = 4;

  logic clk;
  logic rst;

  pla_sop_pipe_if #(.N_IN(NI), .N_TERMS(NT), .IDX_W(IW)) bus ();

  pla_sop_pipe #(.N_IN(NI), .N_TERMS(NT), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [NT-1:0]   exp_q[$];
  int              acc_q[$];
  int              now_edge = 0;
  int              pop_count = 0;
  logic            last_accept;
  logic            m_en   [NT];
  logic [NI-1:0]   m_mask [NT];
  logic [NI-1:0]   m_val  [NT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    acc_q.delete();
    for (int t = 0; t < NT; t++) begin
      m_en[t]   = 1'b0;
      m_mask[t] = '0;
      m_val[t]  = '0;
    end
  endtask

  // Literal-by-literal evaluation of every implicant.
  function automatic logic [NT-1:0] ref_hits(input logic [NI-1:0] v);
    logic [NT-1:0] r;
    logic          match;
    r = '0;
    for (int t = 0; t < NT; t++) begin
      match = m_en[t];
      for (int j = 0; j < NI; j++) begin
        if (m_mask[t][j] && (v[j] != m_val[t][j])) match = 1'b0;
      end
      r[t] = match;
    end
    return r;
  endfunction

  function automatic logic model_out_valid();
    return (exp_q.size() != 0) && (acc_q[0] < now_edge);
  endfunction

  function automatic logic model_in_ready();
    return !((exp_q.size() >= 2) && !bus.out_ready);
  endfunction

  task automatic compare_outputs();
    logic mov;
    mov = model_out_valid();
    check("out_valid", 32'(bus.out_valid), 32'(mov));
    check("in_ready", 32'(bus.in_ready), 32'(model_in_ready()));
    if (mov) begin
      check("out_hits", 32'(bus.out_hits), 32'(exp_q[0]));
      check("out_f", 32'(bus.out_f), 32'(|exp_q[0]));
    end
  endtask

  // Applies the effect of the coming rising edge to the model; inputs are stable here.
  task automatic model_edge();
    logic acc;
    logic pop;
    logic [NT-1:0] h;
    last_accept = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    acc = bus.in_valid && model_in_ready();
    pop = model_out_valid() && bus.out_ready;
    h   = ref_hits(bus.in_data);  // table as it stands before this edge
    if (pop) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
      pop_count++;
    end
    now_edge++;
    if (acc) begin
      exp_q.push_back(h);
      acc_q.push_back(now_edge);
    end
    if (bus.cfg_we && (int'(bus.cfg_idx) < NT)) begin
      m_en[bus.cfg_idx]   = bus.cfg_en;
      m_mask[bus.cfg_idx] = bus.cfg_mask;
      m_val[bus.cfg_idx]  = bus.cfg_val;
    end
    last_accept = acc;
  endtask

  // One clock: check at the falling edge, advance the model, return 1 unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int idx, input logic en, input logic [NI-1:0] mask,
                           input logic [NI-1:0] val);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = IW'(idx);
    bus.cfg_en   = en;
    bus.cfg_mask = mask;
    bus.cfg_val  = val;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic send_one(input string tag, input logic [NI-1:0] data, input logic [NT-1:0] exp_hits);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_hits"}, 32'(bus.out_hits), 32'(exp_hits));
    check({tag, "_f"}, 32'(bus.out_f), 32'(|exp_hits));
    tick();
  endtask

  // ---------------- directed / random sequence ----------------
  initial begin
    logic [NI-1:0] stream_vec [6];
    int            fed;
    int            drop_fed;

    rst          = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_idx  = '0;
    bus.cfg_en   = 1'b0;
    bus.cfg_mask = '0;
    bus.cfg_val  = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_f", 32'(bus.out_f), 32'd0);
    check("rst_out_hits", 32'(bus.out_hits), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Empty table: two edges to a result, all-zero hits.
    bus.in_valid = 1'b1;
    bus.in_data  = 5'b10101;
    tick();
    bus.in_valid = 1'b0;
    check("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    check("lat_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
    check("empty_hits", 32'(bus.out_hits), 32'h00);
    check("empty_f", 32'(bus.out_f), 32'd0);
    tick();

    // Two programmed implicants.
    cfg_write(0, 1'b1, 5'b11001, 5'b00000);
    cfg_write(1, 1'b1, 5'b01110, 5'b00010);
    send_one("v00100", 5'b00100, 8'h01);
    send_one("v10010", 5'b10010, 8'h02);
    send_one("v11111", 5'b11111, 8'h00);

    // Back-to-back stream, output stalled during cycles 3..6.
    for (int i = 0; i < 6; i++) stream_vec[i] = NI'($urandom_range(0, 31));
    fed = 0;
    drop_fed = -1;
    pop_count = 0;
    for (int c = 1; c <= 40; c++) begin
      if (fed == 6 && exp_q.size() == 0) break;
      bus.out_ready = !(c >= 3 && c <= 6);
      bus.in_valid  = (fed < 6);
      bus.in_data   = (fed < 6) ? stream_vec[fed] : '0;
      #1;
      if (!bus.in_ready && drop_fed < 0) drop_fed = fed;
      tick();
      if (last_accept) fed++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_drop_after", 32'(drop_fed), 32'd2);
    check("stream_fed", 32'(fed), 32'd6);
    check("stream_popped", 32'(pop_count), 32'd6);

    // Table write and accept on the same edge: the accepted vector sees the old slot 0.
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = IW'(0);
    bus.cfg_en   = 1'b0;
    bus.cfg_mask = 5'b11001;
    bus.cfg_val  = 5'b00000;
    bus.in_valid = 1'b1;
    bus.in_data  = 5'b00100;
    tick();
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("same_edge_valid", 32'(bus.out_valid), 32'd1);
    check("same_edge_hits", 32'(bus.out_hits), 32'h01);
    tick();
    send_one("after_disable", 5'b00100, 8'h00);

    // Constant-1 slot, then an out-of-range index write that must be ignored.
    cfg_write(7, 1'b1, 5'b00000, 5'b00000);
    send_one("const1_a", 5'b01010, 8'h80);
    send_one("const1_b", 5'b00000, 8'h80);
    cfg_write(8, 1'b1, 5'b00000, 5'b00000);
    send_one("idx8_ignored", 5'b10101, 8'h80);

    // Randomized traffic, table writes and back-pressure.
    for (int c = 0; c < 400; c++) begin
      bus.cfg_we    = ($urandom_range(0, 5) == 0);
      bus.cfg_idx   = IW'($urandom_range(0, 15));
      bus.cfg_en    = 1'($urandom_range(0, 3) != 0);
      bus.cfg_mask  = NI'($urandom_range(0, 31));
      bus.cfg_val   = NI'($urandom_range(0, 31));
      bus.in_valid  = 1'($urandom_range(0, 2) != 0);
      bus.in_data   = NI'($urandom_range(0, 31));
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    bus.cfg_we    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Reset with two results in flight.
    cfg_write(7, 1'b1, 5'b00000, 5'b00000);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 5'b00011;
    tick();
    bus.in_data   = 5'b11100;
    tick();
    bus.in_valid  = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_hits", 32'(bus.out_hits), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    send_one("post_rst_cleared", 5'b11111, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
